// File: rtl/led4_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led4_seq_ctrl
// Description : Four-LED one-hot sequencer with a command port. Commands set
//               the step period, the sequence mode (rotate-up, rotate-down,
//               ping-pong) and start/stop the sequence. Every accepted command
//               passes through a one-cycle APPLY state before the sequencer
//               resumes in RUN or STOP.
// Revision    : 1.0 - initial release
// ============================================================================
module led4_seq_ctrl #(
  parameter int PW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [PW-1:0] cmd_data,
  output logic [3:0]    diode,
  output logic          step,
  output logic          running
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  localparam logic [1:0] c_OP_STOP    = 2'b00;
  localparam logic [1:0] c_OP_RUN     = 2'b01;
  localparam logic [1:0] c_OP_SETPER  = 2'b10;
  localparam logic [1:0] c_OP_SETMODE = 2'b11;

  localparam logic [1:0] c_MODE_UP   = 2'b00;
  localparam logic [1:0] c_MODE_DOWN = 2'b01;
  localparam logic [1:0] c_MODE_PP   = 2'b10;
  localparam logic [1:0] c_MODE_RSVD = 2'b11;

  localparam logic [PW-1:0] c_PERIOD_RST = PW'(4);

  state_t        r_state;
  logic          r_run;
  logic [PW-1:0] r_period;
  logic [1:0]    r_mode;
  logic          r_dir;
  logic [PW-1:0] r_count;

  logic          w_accept;
  logic [PW-1:0] w_last_count;
  logic          w_adv;
  logic          w_onehot;
  logic [3:0]    w_next_diode;
  logic          w_next_dir;
  logic [3:0]    w_diode_after;

  assign w_accept      = cmd_valid & cmd_ready;
  // Period 0 behaves as period 1, so the terminal count is 0 in both cases.
  assign w_last_count  = (r_period == '0) ? '0 : (r_period - PW'(1));
  assign w_adv         = (r_state == ST_RUN) && (r_count == w_last_count);
  assign w_diode_after = w_adv ? w_next_diode : diode;

  // Next LED pattern and ping-pong direction for the coming step.
  always_comb begin
    w_onehot     = (diode == 4'b0001) || (diode == 4'b0010) ||
                   (diode == 4'b0100) || (diode == 4'b1000);
    w_next_diode = 4'b0001;
    w_next_dir   = r_dir;
    if (w_onehot) begin
      case (r_mode)
        c_MODE_UP:   w_next_diode = {diode[2:0], diode[3]};
        c_MODE_DOWN: w_next_diode = {diode[0], diode[3:1]};
        c_MODE_PP:   w_next_diode = r_dir ? {diode[2:0], 1'b0} : {1'b0, diode[3:1]};
        default:     w_next_diode = diode;
      endcase
    end
    if (r_mode == c_MODE_PP) begin
      if (w_next_diode == 4'b1000)
        w_next_dir = 1'b0;
      else if (w_next_diode == 4'b0001)
        w_next_dir = 1'b1;
    end
  end

  // Control FSM, prescaler, LED pattern and command register updates.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_STOP;
      r_run     <= 1'b0;
      r_period  <= c_PERIOD_RST;
      r_mode    <= c_MODE_UP;
      r_dir     <= 1'b1;
      r_count   <= '0;
      diode     <= 4'b0001;
      step      <= 1'b0;
      running   <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      step <= 1'b0;
      case (r_state)
        ST_STOP: begin
          r_count <= '0;
          if (w_accept) begin
            r_state   <= ST_APPLY;
            cmd_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_adv) begin
            r_count <= '0;
            step    <= 1'b1;
            diode   <= w_next_diode;
            r_dir   <= w_next_dir;
          end else begin
            r_count <= r_count + PW'(1);
          end
          if (w_accept) begin
            r_state   <= ST_APPLY;
            cmd_ready <= 1'b0;
            running   <= 1'b0;
          end
        end
        ST_APPLY: begin
          r_count   <= '0;
          cmd_ready <= 1'b1;
          if (r_run) begin
            r_state <= ST_RUN;
            running <= 1'b1;
          end else begin
            r_state <= ST_STOP;
            running <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_STOP;
          r_count   <= '0;
          cmd_ready <= 1'b1;
          running   <= 1'b0;
        end
      endcase

      // Command side effects land on the accepting edge; a mode change into
      // ping-pong seeds the direction from the pattern shown after this edge.
      if (w_accept) begin
        case (cmd_op)
          c_OP_STOP:   r_run    <= 1'b0;
          c_OP_RUN:    r_run    <= 1'b1;
          c_OP_SETPER: r_period <= cmd_data;
          c_OP_SETMODE: begin
            if (cmd_data[1:0] != c_MODE_RSVD) begin
              r_mode <= cmd_data[1:0];
              if ((cmd_data[1:0] == c_MODE_PP) && (r_mode != c_MODE_PP))
                r_dir <= (w_diode_after != 4'b1000);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led4_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led4_seq_ctrl
// Description : Directed self-checking bench for led4_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led4_seq_ctrl;

  localparam int PW = 16;

  logic          clock;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [PW-1:0] cmd_data;
  logic [3:0]    diode;
  logic          step;
  logic          running;

  int checks;
  int errors;

  led4_seq_ctrl #(.PW(PW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .diode     (diode),
    .step      (step),
    .running   (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    #3;
    tick();
    reset_n = 1'b1;
  endtask

  // Offer one command, let it be accepted, then wait out APPLY.
  task automatic send_cmd(input logic [1:0] op, input logic [PW-1:0] data);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (diode !== 4'b0001 || step !== 1'b0 || running !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: diode=%b step=%b running=%b ready=%b expected 0001 0 0 1",
               name, diode, step, running, cmd_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset_state");
  endtask

  task automatic test_run_default();
    logic [3:0] exp_d;
    do_reset();
    cmd_op = 2'b01; cmd_data = '0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL run_apply: ready=%b running=%b expected 0 0", cmd_ready, running);
    end
    tick();
    checks++;
    if (running !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_enter: running=%b ready=%b expected 1 1", running, cmd_ready);
    end
    exp_d = 4'b0001;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i % 4 == 0) exp_d = {exp_d[2:0], exp_d[3]};
      checks++;
      if (step !== ((i % 4) == 0) || diode !== exp_d) begin
        errors++;
        $display("FAIL run_default cyc%0d: step=%b diode=%b expected %b %b",
                 i, step, diode, ((i % 4) == 0), exp_d);
      end
    end
  endtask

  task automatic test_rotate_down();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    do_reset();
    send_cmd(2'b10, 16'd0);
    send_cmd(2'b11, 16'd1);
    send_cmd(2'b01, 16'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (step !== 1'b1 || diode !== exp_seq[i]) begin
        errors++;
        $display("FAIL rotate_down step%0d: step=%b diode=%b expected 1 %b",
                 i, step, diode, exp_seq[i]);
      end
    end
  endtask

  task automatic test_pingpong();
    logic [3:0] exp_seq [10];
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
    do_reset();
    send_cmd(2'b10, 16'd1);
    send_cmd(2'b11, 16'd2);
    send_cmd(2'b01, 16'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (step !== 1'b1 || diode !== exp_seq[i]) begin
        errors++;
        $display("FAIL pingpong step%0d: step=%b diode=%b expected 1 %b",
                 i, step, diode, exp_seq[i]);
      end
    end
  endtask

  task automatic test_stop_resume();
    do_reset();
    send_cmd(2'b01, 16'd0);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (diode !== 4'b0010) begin
      errors++;
      $display("FAIL stop_pre: diode=%b expected 0010", diode);
    end
    send_cmd(2'b00, 16'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (diode !== 4'b0010 || step !== 1'b0 || running !== 1'b0) begin
        errors++;
        $display("FAIL stop_frozen cyc%0d: diode=%b step=%b running=%b expected 0010 0 0",
                 i, diode, step, running);
      end
      tick();
    end
    send_cmd(2'b01, 16'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (step !== (i == 4) || diode !== ((i == 4) ? 4'b0100 : 4'b0010)) begin
        errors++;
        $display("FAIL resume cyc%0d: step=%b diode=%b expected %b %b",
                 i, step, diode, (i == 4), ((i == 4) ? 4'b0100 : 4'b0010));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    ops   [3];
    logic [PW-1:0] datas [3];
    ops   = '{2'b10, 2'b11, 2'b01};
    datas = '{16'd2, 16'd3, 16'd0};
    do_reset();
    cmd_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_hi cmd%0d: ready=%b expected 1", c, cmd_ready);
      end
      cmd_op   = ops[c];
      cmd_data = datas[c];
      tick();
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_lo cmd%0d: ready=%b expected 0", c, cmd_ready);
      end
      if (c == 2) cmd_valid = 1'b0;
      tick();
    end
    checks++;
    if (cmd_ready !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL b2b_final: ready=%b running=%b expected 1 1", cmd_ready, running);
    end
    tick();
    checks++;
    if (step !== 1'b0 || diode !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_cnt1: step=%b diode=%b expected 0 0001", step, diode);
    end
    tick();
    checks++;
    if (step !== 1'b1 || diode !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_step: step=%b diode=%b expected 1 0010", step, diode);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_cmd(2'b10, 16'd1);
    send_cmd(2'b01, 16'd0);
    tick();
    tick();
    checks++;
    if (diode !== 4'b0100 || running !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: diode=%b running=%b expected 0100 1", diode, running);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("areset_run");
    tick();
    reset_n = 1'b1;
    // Reset during APPLY must drop the pending RUN.
    cmd_op = 2'b01; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("areset_apply");
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check_idle_outputs("areset_discard");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    test_reset();
    test_run_default();
    test_rotate_down();
    test_pingpong();
    test_stop_resume();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
